// File: rtl/unidade_controle_exp4.sv
// Moore control unit sequencing a 16-position compare sweep.
// Optional ERRO_STOP_EN: end the sweep at the first mismatch.
module unidade_controle_exp4 (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       igual,
    input  logic       fim,
    output logic       zera,
    output logic       registra,
    output logic       conta,
    output logic       pronto,
    output logic       acertou,
    output logic [4:0] erros,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL  = 4'h0,
        PREPARA  = 4'h1,
        ESPERA   = 4'h2,
        REGISTRA = 4'h4,
        COMPARA  = 4'h5,
        PROXIMO  = 4'h6,
        FINAL    = 4'hF
    } estado_t;

    localparam logic [4:0] ERROS_MAX = 5'd16;

    estado_t    estado;
    estado_t    estado_d;
    logic       jogada_q;
    logic       jogada_ed;
    logic       erro_cmp;
    logic [4:0] erros_d;

    // Rising edge of the move strobe; a held level is one move.
    assign jogada_ed = jogada & ~jogada_q;

    // A mismatch is only meaningful while comparing.
    assign erro_cmp = (estado == COMPARA) & ~igual;

    // State register and edge-detector history.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado   <= INICIAL;
            jogada_q <= 1'b0;
        end else begin
            estado   <= estado_d;
            jogada_q <= jogada;
        end
    end

    // Next-state logic; unknown codes fall back to INICIAL.
    always_comb begin
        estado_d = INICIAL;
        case (estado)
            INICIAL: begin
                estado_d = iniciar ? PREPARA : INICIAL;
            end
            PREPARA: begin
                estado_d = ESPERA;
            end
            ESPERA: begin
                estado_d = jogada_ed ? REGISTRA : ESPERA;
            end
            REGISTRA: begin
                estado_d = COMPARA;
            end
            COMPARA: begin
`ifdef ERRO_STOP_EN
                if (!igual || fim)
                    estado_d = FINAL;
                else
                    estado_d = PROXIMO;
`else
                estado_d = fim ? FINAL : PROXIMO;
`endif
            end
            PROXIMO: begin
                estado_d = ESPERA;
            end
            FINAL: begin
                estado_d = iniciar ? PREPARA : FINAL;
            end
            default: begin
                estado_d = INICIAL;
            end
        endcase
    end

    // Mismatch counter: cleared on prepare, saturating at 16.
    always_comb begin
        erros_d = erros;
        if (estado == PREPARA)
            erros_d = 5'd0;
        else if (erro_cmp && (erros != ERROS_MAX))
            erros_d = erros + 5'd1;
    end

    // Mismatch count register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            erros <= 5'd0;
        else
            erros <= erros_d;
    end

    // Moore outputs decoded purely from the registered state.
    always_comb begin
        zera      = (estado == PREPARA);
        registra  = (estado == REGISTRA);
        conta     = (estado == PROXIMO);
        pronto    = (estado == FINAL);
        acertou   = (estado == FINAL) & (erros == 5'd0);
        db_estado = estado;
    end

endmodule

// File: tb/tb_unidade_controle_exp4.sv
// Directed bench for unidade_controle_exp4.
// Covers reset, full sweeps, saturation, held moves and restart.
module tb_unidade_controle_exp4;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic       jogada;
    logic       igual;
    logic       fim;
    logic       zera;
    logic       registra;
    logic       conta;
    logic       pronto;
    logic       acertou;
    logic [4:0] erros;
    logic [3:0] db_estado;

    int vectors = 0;
    int errors  = 0;
    int conta_cnt = 0;
    int reg_cnt = 0;

    localparam logic [3:0] ST_INI = 4'h0;
    localparam logic [3:0] ST_PRE = 4'h1;
    localparam logic [3:0] ST_ESP = 4'h2;
    localparam logic [3:0] ST_CMP = 4'h5;
    localparam logic [3:0] ST_FIN = 4'hF;

    unidade_controle_exp4 dut (
        .clock    (clock),
        .reset    (reset),
        .iniciar  (iniciar),
        .jogada   (jogada),
        .igual    (igual),
        .fim      (fim),
        .zera     (zera),
        .registra (registra),
        .conta    (conta),
        .pronto   (pronto),
        .acertou  (acertou),
        .erros    (erros),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    // Strobe pulse counters, sampled mid-cycle.
    always @(negedge clock) begin
        if (conta)
            conta_cnt++;
        if (registra)
            reg_cnt++;
    end

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_state(input string tag, input logic [3:0] dest,
                              input int budget);
        for (int i = 0; i < budget; i++) begin
            step();
            if (db_estado === dest)
                break;
        end
        check(tag, {4'h0, db_estado}, {4'h0, dest});
    endtask

    task automatic do_move(input logic ig, input logic fm,
                           input logic [3:0] dest);
        igual  = ig;
        fim    = fm;
        jogada = 1'b1;
        step();
        jogada = 1'b0;
        wait_state("move_end", dest, 8);
    endtask

    task automatic start_sweep();
        iniciar = 1'b1;
        step();
        check("prep_state", {4'h0, db_estado}, 8'h01);
        check("prep_zera", {7'h0, zera}, 8'h01);
        iniciar = 1'b0;
        step();
        check("wait_state", {4'h0, db_estado}, 8'h02);
        check("wait_zera", {7'h0, zera}, 8'h00);
        check("wait_erros", {3'h0, erros}, 8'h00);
    endtask

    initial begin
        reset   = 1'b1;
        iniciar = 1'b0;
        jogada  = 1'b0;
        igual   = 1'b1;
        fim     = 1'b0;
        #2;
        check("rst_state", {4'h0, db_estado}, 8'h00);
        check("rst_erros", {3'h0, erros}, 8'h00);
        check("rst_strobes", {5'h0, zera, registra, conta}, 8'h00);
        check("rst_pronto", {6'h0, pronto, acertou}, 8'h00);
        step();
        step();
        reset = 1'b0;
        step();
        check("idle_state", {4'h0, db_estado}, 8'h00);

        // All-correct sweep.
        conta_cnt = 0;
        start_sweep();
        for (int i = 0; i < 15; i++)
            do_move(1'b1, 1'b0, ST_ESP);
        do_move(1'b1, 1'b1, ST_FIN);
        check("ok_pronto", {7'h0, pronto}, 8'h01);
        check("ok_acertou", {7'h0, acertou}, 8'h01);
        check("ok_erros", {3'h0, erros}, 8'h00);
        check("ok_conta", conta_cnt[7:0], 8'd15);
        step();
        check("ok_hold", {4'h0, db_estado}, {4'h0, ST_FIN});

`ifdef ERRO_STOP_EN
        // Stop at the first mismatch on move 3.
        conta_cnt = 0;
        start_sweep();
        do_move(1'b1, 1'b0, ST_ESP);
        do_move(1'b1, 1'b0, ST_ESP);
        do_move(1'b0, 1'b0, ST_FIN);
        check("stop_erros", {3'h0, erros}, 8'h01);
        check("stop_pronto", {7'h0, pronto}, 8'h01);
        check("stop_acertou", {7'h0, acertou}, 8'h00);
        check("stop_conta", conta_cnt[7:0], 8'd2);
        // Moves in FINAL are ignored.
        do_move(1'b0, 1'b0, ST_FIN);
        check("stop_ign", {3'h0, erros}, 8'h01);
        iniciar = 1'b1;
        step();
        check("rs_state", {4'h0, db_estado}, 8'h01);
        check("rs_erros_hold", {3'h0, erros}, 8'h01);
        iniciar = 1'b0;
        step();
        check("rs_erros_clr", {3'h0, erros}, 8'h00);
`else
        // All-wrong sweep with a 17th compare to probe saturation.
        start_sweep();
        for (int i = 0; i < 16; i++)
            do_move(1'b0, 1'b0, ST_ESP);
        check("bad_16", {3'h0, erros}, 8'd16);
        do_move(1'b0, 1'b1, ST_FIN);
        check("bad_sat", {3'h0, erros}, 8'd16);
        check("bad_acertou", {7'h0, acertou}, 8'h00);
        check("bad_pronto", {7'h0, pronto}, 8'h01);

        // Sweep with 5 mismatches, then restart from FINAL.
        start_sweep();
        for (int i = 0; i < 15; i++)
            do_move((i % 3) != 0, 1'b0, ST_ESP);
        do_move(1'b1, 1'b1, ST_FIN);
        check("five_erros", {3'h0, erros}, 8'd5);
        check("five_acertou", {7'h0, acertou}, 8'h00);
        iniciar = 1'b1;
        step();
        check("rs_state", {4'h0, db_estado}, 8'h01);
        check("rs_zera", {7'h0, zera}, 8'h01);
        check("rs_erros_hold", {3'h0, erros}, 8'd5);
        iniciar = 1'b0;
        step();
        check("rs_erros_clr", {3'h0, erros}, 8'h00);
`endif

        // Held move: one registra pulse, then waits in ESPERA.
        check("held_start", {4'h0, db_estado}, {4'h0, ST_ESP});
        reg_cnt = 0;
        igual  = 1'b1;
        fim    = 1'b0;
        jogada = 1'b1;
        repeat (10) step();
        check("held_state", {4'h0, db_estado}, {4'h0, ST_ESP});
        jogada = 1'b0;
        step();
        check("held_reg", reg_cnt[7:0], 8'd1);

`ifndef ERRO_STOP_EN
        // Three mismatches, then reset while in COMPARA.
        for (int i = 0; i < 3; i++)
            do_move(1'b0, 1'b0, ST_ESP);
        check("pre_rst_erros", {3'h0, erros}, 8'd3);
`endif
        igual  = 1'b1;
        jogada = 1'b1;
        step();
        jogada = 1'b0;
        step();
        check("cmp_state", {4'h0, db_estado}, {4'h0, ST_CMP});
        #2;
        reset = 1'b1;
        #1;
        check("ar_state", {4'h0, db_estado}, 8'h00);
        check("ar_erros", {3'h0, erros}, 8'h00);
        check("ar_strobes", {5'h0, zera, registra, conta}, 8'h00);
        step();
        reset = 1'b0;
        step();
        check("ar_idle", {4'h0, db_estado}, {4'h0, ST_INI});
        check("ar_pre", {7'h0, db_estado == ST_PRE}, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule

// File: doc/unidade_controle_exp4.md
# unidade_controle_exp4

Moore control unit that sequences the counter/comparator datapath through a 16-position comparison sweep. It drives the datapath's `zera`, `registra` and `conta` strobes and consumes the datapath's `igual` and `fim` status. It counts mismatches between the switch value and the counter value, one compare per player move (`jogada`), and reports the result when the sweep ends.

## Interface
- No parameters. State encoding and widths are fixed.
- `clock` in 1: single system clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high; forces INICIAL and clears all registers.
- `iniciar` in 1: level; starts a sweep from INICIAL or FINAL.
- `jogada` in 1: move strobe, any length; only its rising edge is used.
- `igual` in 1: datapath comparator equal (counter == latched switches).
- `fim` in 1: datapath counter terminal count (counter == 15).
- `zera` out 1: datapath clear strobe.
- `registra` out 1: datapath switch-latch strobe.
- `conta` out 1: datapath counter-enable strobe.
- `pronto` out 1: sweep finished.
- `acertou` out 1: sweep finished with zero mismatches.
- `erros` out 5: mismatch count, range 0..16.
- `db_estado` out 4: current state code for hexa7seg debug display.

## Operation
- States and codes:
  - INICIAL=0
  - PREPARA=1
  - ESPERA=2
  - REGISTRA=4
  - COMPARA=5
  - PROXIMO=6
  - FINAL=F
  - Any other code goes to INICIAL on the next edge.
- Transitions:
  - INICIAL: `iniciar` -> PREPARA; else stay.
  - PREPARA -> ESPERA unconditionally. `zera`=1. `erros` cleared to 0 at this edge.
  - ESPERA: `jogada` rising edge -> REGISTRA; else stay.
  - REGISTRA -> COMPARA unconditionally. `registra`=1.
  - COMPARA: if `igual`=0, `erros` increments at this edge. Then `fim`=1 -> FINAL; else -> PROXIMO.
  - PROXIMO -> ESPERA unconditionally. `conta`=1.
  - FINAL: `pronto`=1; `iniciar` -> PREPARA; else stay.
- Edge detector: register `jogada_q` (reset 0). Edge = `jogada` & ~`jogada_q`. A held-high `jogada` counts as one move only.
- `erros`:
  - 5-bit register; saturates at 16 and never wraps.
  - Holds its value in FINAL until the next PREPARA.
- `acertou` = `pronto` & (`erros`==0).
- Ignored inputs:
  - `iniciar` outside INICIAL/FINAL.
  - `jogada` edges outside ESPERA; these edges are consumed and not queued.
  - `igual` and `fim` outside COMPARA.

## Timing
- All outputs are decoded from registered state (plus the `erros` register). No combinational path from inputs to outputs.
- Reset values:
  - State = INICIAL.
  - `zera`, `registra`, `conta`, `pronto`, `acertou` = 0.
  - `erros` = 0; `db_estado` = 0; `jogada_q` = 0.
- Each strobe (`zera`, `registra`, `conta`) is high for exactly one clock per visit to its state.
- Latency:
  - `iniciar` sampled at edge n -> `zera` high in cycle n+1.
  - `jogada` edge sampled at edge n -> `registra` high n+1, compare n+2, `conta` high n+3 (if not final).
- Full sweep: 16 moves; the 16th compare (`fim`=1) goes to FINAL with no `conta`, so the counter stays at 15.
- Simultaneous `fim`=1 and `igual`=0 in COMPARA: the increment and the transition to FINAL both happen at the same edge.
- `reset` mid-sweep: immediate return to INICIAL, `erros`=0, strobes drop asynchronously.

## Configuration
- `ERRO_STOP_EN` defined:
  - In COMPARA, `igual`=0 -> FINAL regardless of `fim`.
  - `erros` becomes 1 and `acertou`=0.
  - A sweep ends at the first mismatch.
- `ERRO_STOP_EN` undefined:
  - All 16 positions are compared; `erros` holds the total, 0..16.

## Test plan
- Reset mid-sweep: assert `reset` while in COMPARA with `erros`=3 -> state 0, all strobes 0, `erros`=0 with no clock edge needed.
- All-correct sweep: `iniciar`, then 16 `jogada` edges with `igual`=1 and `fim`=1 on the 16th -> `pronto`=1, `acertou`=1, `erros`=0, and `conta` pulsed exactly 15 times.
- All-wrong sweep (macro off): 16 moves with `igual`=0 -> `erros`=16 and not 17 on a 17th attempt; `acertou`=0.
- Held `jogada`: keep `jogada` high for 10 cycles in ESPERA -> exactly one `registra` pulse; state returns to ESPERA and waits.
- `ERRO_STOP_EN` defined: `igual`=0 on the 3rd move -> FINAL after that COMPARA, `erros`=1, `pronto`=1, `conta` pulsed 2 times total.
- Restart from FINAL: `iniciar` in FINAL with `erros`=5 -> PREPARA, `zera` pulse, `erros`=0 on the following cycle.
